axi_clint_xbar: RTL and testbench

- AXI4 1-master-to-2-slave crossbar between the LSU data port and its two targets: the CLINT timer slave (read-only, single beat) and the SoC/memory AXI port.
- Decodes each read and write address, routes the transaction to the selected slave, and returns the response on the master port.
- Generates `rlast`/`rid` locally for the CLINT, which does not supply them.
- Answers writes to the CLINT region itself with DECERR.
- Read and write paths are independent. Each path allows one outstanding transaction.

---
 rtl/axi_clint_xbar.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_clint_xbar.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_clint_xbar.sv
// AXI4 1-to-2 crossbar: LSU data port to the CLINT (read-only, single beat) and the SoC port.
// Independent read and write FSMs, one outstanding transaction per direction.
module axi_clint_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  // master read address / data
  input  logic        m_arvalid,
  input  logic [31:0] m_araddr,
  input  logic [3:0]  m_arid,
  input  logic [7:0]  m_arlen,
  input  logic [2:0]  m_arsize,
  input  logic [1:0]  m_arburst,
  output logic        m_arready,
  output logic        m_rvalid,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rlast,
  output logic [3:0]  m_rid,
  input  logic        m_rready,
  // master write address / data / response
  input  logic        m_awvalid,
  input  logic [31:0] m_awaddr,
  input  logic [3:0]  m_awid,
  input  logic [7:0]  m_awlen,
  input  logic [2:0]  m_awsize,
  input  logic [1:0]  m_awburst,
  output logic        m_awready,
  input  logic        m_wvalid,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wlast,
  output logic        m_wready,
  output logic        m_bvalid,
  output logic [1:0]  m_bresp,
  output logic [3:0]  m_bid,
  input  logic        m_bready,
  // CLINT read port
  output logic        s0_arvalid,
  output logic [31:0] s0_araddr,
  output logic [3:0]  s0_arid,
  output logic [7:0]  s0_arlen,
  output logic [2:0]  s0_arsize,
  output logic [1:0]  s0_arburst,
  input  logic        s0_arready,
  input  logic        s0_rvalid,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,
  output logic        s0_rready,
  // SoC port
  output logic        s1_arvalid,
  output logic [31:0] s1_araddr,
  output logic [3:0]  s1_arid,
  output logic [7:0]  s1_arlen,
  output logic [2:0]  s1_arsize,
  output logic [1:0]  s1_arburst,
  input  logic        s1_arready,
  input  logic        s1_rvalid,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp,
  input  logic        s1_rlast,
  input  logic [3:0]  s1_rid,
  output logic        s1_rready,
  output logic        s1_awvalid,
  output logic [31:0] s1_awaddr,
  output logic [3:0]  s1_awid,
  output logic [7:0]  s1_awlen,
  output logic [2:0]  s1_awsize,
  output logic [1:0]  s1_awburst,
  input  logic        s1_awready,
  output logic        s1_wvalid,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  output logic        s1_wlast,
  input  logic        s1_wready,
  input  logic        s1_bvalid,
  input  logic [1:0]  s1_bresp,
  input  logic [3:0]  s1_bid,
  output logic        s1_bready
);

  typedef enum logic [1:0] {RIdle, RClint, RSoc} r_state_t;
  typedef enum logic [1:0] {WIdle, WSoc, WDrain, WErrb} w_state_t;

  r_state_t   r_state_q, r_state_d;
  w_state_t   w_state_q, w_state_d;
  logic [3:0] r_id_q, r_id_d;
  logic [3:0] w_id_q, w_id_d;
  logic       ar_clint, aw_clint;

  assign ar_clint = (m_araddr & CLINT_MASK) == CLINT_BASE;
  assign aw_clint = (m_awaddr & CLINT_MASK) == CLINT_BASE;

  // Payloads are broadcast; only the handshake signals are steered.
  assign s0_araddr  = m_araddr;
  assign s0_arid    = m_arid;
  assign s0_arlen   = m_arlen;
  assign s0_arsize  = m_arsize;
  assign s0_arburst = m_arburst;
  assign s1_araddr  = m_araddr;
  assign s1_arid    = m_arid;
  assign s1_arlen   = m_arlen;
  assign s1_arsize  = m_arsize;
  assign s1_arburst = m_arburst;
  assign s1_awaddr  = m_awaddr;
  assign s1_awid    = m_awid;
  assign s1_awlen   = m_awlen;
  assign s1_awsize  = m_awsize;
  assign s1_awburst = m_awburst;
  assign s1_wdata   = m_wdata;
  assign s1_wstrb   = m_wstrb;
  assign s1_wlast   = m_wlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= RIdle;
      w_state_q <= WIdle;
      r_id_q    <= 4'd0;
      w_id_q    <= 4'd0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_id_q    <= r_id_d;
      w_id_q    <= w_id_d;
    end
  end

  // Read path
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = 32'd0;
    m_rresp    = 2'd0;
    m_rlast    = 1'b0;
    m_rid      = 4'd0;
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_rready  = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (ar_clint) begin
          s0_arvalid = m_arvalid;
          m_arready  = s0_arready;
        end else begin
          s1_arvalid = m_arvalid;
          m_arready  = s1_arready;
        end
        if (m_arvalid && m_arready) begin
          r_id_d    = m_arid;
          r_state_d = ar_clint ? RClint : RSoc;
        end
      end
      RClint: begin
        // CLINT has no rlast/rid; it always answers with a single beat.
        m_rvalid  = s0_rvalid;
        m_rdata   = s0_rdata;
        m_rresp   = s0_rresp;
        m_rlast   = 1'b1;
        m_rid     = r_id_q;
        s0_rready = m_rready;
        if (s0_rvalid && m_rready) r_state_d = RIdle;
      end
      RSoc: begin
        m_rvalid  = s1_rvalid;
        m_rdata   = s1_rdata;
        m_rresp   = s1_rresp;
        m_rlast   = s1_rlast;
        m_rid     = s1_rid;
        s1_rready = m_rready;
        if (s1_rvalid && m_rready && s1_rlast) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
    if (reset) begin
      m_arready  = 1'b0;
      m_rvalid   = 1'b0;
      m_rdata    = 32'd0;
      m_rresp    = 2'd0;
      m_rlast    = 1'b0;
      m_rid      = 4'd0;
      s0_arvalid = 1'b0;
      s1_arvalid = 1'b0;
      s0_rready  = 1'b0;
      s1_rready  = 1'b0;
    end
  end

  // Write path; CLINT writes are absorbed here and answered with DECERR.
  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    m_awready  = 1'b0;
    m_wready   = 1'b0;
    m_bvalid   = 1'b0;
    m_bresp    = 2'd0;
    m_bid      = 4'd0;
    s1_awvalid = 1'b0;
    s1_wvalid  = 1'b0;
    s1_bready  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_clint) begin
          m_awready = 1'b1;
          if (m_awvalid) begin
            w_id_d    = m_awid;
            w_state_d = WDrain;
          end
        end else begin
          s1_awvalid = m_awvalid;
          m_awready  = s1_awready;
          if (m_awvalid && s1_awready) w_state_d = WSoc;
        end
      end
      WSoc: begin
        s1_wvalid = m_wvalid;
        m_wready  = s1_wready;
        m_bvalid  = s1_bvalid;
        m_bresp   = s1_bresp;
        m_bid     = s1_bid;
        s1_bready = m_bready;
        if (s1_bvalid && m_bready) w_state_d = WIdle;
      end
      WDrain: begin
        m_wready = 1'b1;
        if (m_wvalid && m_wlast) w_state_d = WErrb;
      end
      WErrb: begin
        m_bvalid = 1'b1;
        m_bresp  = 2'b11;
        m_bid    = w_id_q;
        if (m_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
    if (reset) begin
      m_awready  = 1'b0;
      m_wready   = 1'b0;
      m_bvalid   = 1'b0;
      m_bresp    = 2'd0;
      m_bid      = 4'd0;
      s1_awvalid = 1'b0;
      s1_wvalid  = 1'b0;
      s1_bready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_clint_xbar.sv
// Directed bench for axi_clint_xbar: routing, CLINT read, DECERR writes, concurrency, reset.
module tb_axi_clint_xbar;
  logic        clock = 1'b0;
  logic        reset;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb, m_bid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_araddr, s0_rdata;
  logic [3:0]  s0_arid;
  logic [7:0]  s0_arlen;
  logic [2:0]  s0_arsize;
  logic [1:0]  s0_arburst, s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rlast, s1_rready;
  logic [31:0] s1_araddr, s1_rdata;
  logic [3:0]  s1_arid, s1_rid;
  logic [7:0]  s1_arlen;
  logic [2:0]  s1_arsize;
  logic [1:0]  s1_arburst, s1_rresp;
  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wlast, s1_wready, s1_bvalid, s1_bready;
  logic [31:0] s1_awaddr, s1_wdata;
  logic [3:0]  s1_awid, s1_wstrb, s1_bid;
  logic [7:0]  s1_awlen;
  logic [2:0]  s1_awsize;
  logic [1:0]  s1_awburst, s1_bresp;

  int checks = 0;
  int failures = 0;

  axi_clint_xbar dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid),
    .m_bready(m_bready),
    .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arid(s0_arid), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arready(s0_arready),
    .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
    .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arid(s1_arid), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arready(s1_arready),
    .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .s1_rid(s1_rid), .s1_rready(s1_rready),
    .s1_awvalid(s1_awvalid), .s1_awaddr(s1_awaddr), .s1_awid(s1_awid), .s1_awlen(s1_awlen),
    .s1_awsize(s1_awsize), .s1_awburst(s1_awburst), .s1_awready(s1_awready),
    .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_wready(s1_wready), .s1_bvalid(s1_bvalid), .s1_bresp(s1_bresp), .s1_bid(s1_bid),
    .s1_bready(s1_bready)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m_arvalid = 0; m_araddr = 0; m_arid = 0; m_arlen = 0; m_arsize = 3'd2; m_arburst = 2'd1;
    m_rready = 0;
    m_awvalid = 0; m_awaddr = 0; m_awid = 0; m_awlen = 0; m_awsize = 3'd2; m_awburst = 2'd1;
    m_wvalid = 0; m_wdata = 0; m_wstrb = 0; m_wlast = 0; m_bready = 0;
    s0_arready = 0; s0_rvalid = 0; s0_rdata = 0; s0_rresp = 0;
    s1_arready = 0; s1_rvalid = 0; s1_rdata = 0; s1_rresp = 0; s1_rlast = 0; s1_rid = 0;
    s1_awready = 0; s1_wready = 0; s1_bvalid = 0; s1_bresp = 0; s1_bid = 0;
  endtask

  task automatic test_reset();
    logic [16:0] hs;
    logic [43:0] pay;
    idle_inputs();
    reset = 1;
    m_awaddr = 32'h0200_0000;  // CLINT target would otherwise raise m_awready
    step();
    step();
    #1;
    hs = {m_arready, m_rvalid, m_awready, m_wready, m_bvalid, s0_arvalid, s0_rready,
          s1_arvalid, s1_rready, s1_awvalid, s1_wvalid, s1_bready, m_rlast,
          m_rresp, m_bresp};
    pay = {m_rdata, m_rid, m_bid, 4'd0};
    checks++;
    if (hs !== 17'd0) begin
      failures++; $display("FAIL reset_handshakes got=%b exp=0", hs);
    end
    checks++;
    if (pay !== 44'd0) begin
      failures++; $display("FAIL reset_payload got=%h exp=0", pay);
    end
    reset = 0;
    m_awaddr = 32'h0;
    step();
  endtask

  task automatic test_clint_read();
    m_arvalid = 1; m_araddr = 32'h0200_0000; m_arid = 4'd5; s0_arready = 1;
    #1;
    checks++;
    if ({s0_arvalid, s1_arvalid, m_arready} !== 3'b101) begin
      failures++; $display("FAIL clint_ar_route got=%b exp=101", {s0_arvalid, s1_arvalid, m_arready});
    end
    step();
    m_arvalid = 0; s0_arready = 0;
    #1;
    checks++;
    if ({m_arready, m_rvalid} !== 2'b00) begin
      failures++; $display("FAIL clint_wait got=%b exp=00", {m_arready, m_rvalid});
    end
    s0_rvalid = 1; s0_rdata = 32'h1234_5678; s0_rresp = 0; m_rready = 1;
    #1;
    checks++;
    if ({m_rvalid, m_rdata, m_rid, m_rlast, m_rresp, s0_rready, s1_arvalid} !==
        {1'b1, 32'h1234_5678, 4'd5, 1'b1, 2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL clint_rbeat got v=%b d=%h id=%0d last=%b resp=%0d rdy=%b s1av=%b exp 1 12345678 5 1 0 1 0",
               m_rvalid, m_rdata, m_rid, m_rlast, m_rresp, s0_rready, s1_arvalid);
    end
    step();
    s0_rvalid = 0; m_rready = 0;
    #1;
    checks++;
    if ({m_rvalid, m_rid} !== 5'd0) begin
      failures++; $display("FAIL clint_done got v=%b id=%0d exp 0 0", m_rvalid, m_rid);
    end
  endtask

  task automatic test_soc_read();
    m_arvalid = 1; m_araddr = 32'h8000_0000; m_arlen = 8'd3; m_arid = 4'd2; s1_arready = 1;
    #1;
    checks++;
    if ({s1_arvalid, s0_arvalid, m_arready, s1_arlen, s1_arid, s1_araddr} !==
        {3'b101, 8'd3, 4'd2, 32'h8000_0000}) begin
      failures++;
      $display("FAIL soc_ar_route got s1av=%b s0av=%b rdy=%b len=%0d id=%0d addr=%h exp 1 0 1 3 2 80000000",
               s1_arvalid, s0_arvalid, m_arready, s1_arlen, s1_arid, s1_araddr);
    end
    step();
    // keep AR pending on the master to prove it is blocked while busy
    for (int b = 0; b < 4; b++) begin
      s1_rvalid = 1; s1_rdata = 32'hB000_0000 + b; s1_rid = 4'd2; s1_rlast = (b == 3);
      if (b == 1) begin
        m_rready = 0;
        for (int w = 0; w < 2; w++) begin
          #1;
          checks++;
          if ({m_rvalid, s1_rready, m_arready, s1_arvalid} !== 4'b1000) begin
            failures++;
            $display("FAIL soc_stall got=%b exp=1000", {m_rvalid, s1_rready, m_arready, s1_arvalid});
          end
          step();
        end
      end
      m_rready = 1;
      #1;
      checks++;
      if ({m_rvalid, m_rdata, m_rlast, m_rid, s1_rready, m_arready} !==
          {1'b1, 32'hB000_0000 + b, (b == 3), 4'd2, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL soc_beat%0d got v=%b d=%h last=%b id=%0d rdy=%b arrdy=%b", b,
                 m_rvalid, m_rdata, m_rlast, m_rid, s1_rready, m_arready);
      end
      step();
    end
    s1_rvalid = 0; s1_rlast = 0; m_rready = 0;
    #1;
    checks++;
    if ({m_arready, s1_arvalid, m_rvalid} !== 3'b110) begin
      failures++; $display("FAIL soc_turnaround got=%b exp=110", {m_arready, s1_arvalid, m_rvalid});
    end
    m_arvalid = 0; s1_arready = 0; m_arlen = 0;
    step();
  endtask

  task automatic test_clint_write();
    m_awvalid = 1; m_awaddr = 32'h0200_0004; m_awid = 4'd3; s1_awready = 1; s1_wready = 1;
    #1;
    checks++;
    if ({m_awready, s1_awvalid, m_wready} !== 3'b100) begin
      failures++; $display("FAIL clint_aw got=%b exp=100", {m_awready, s1_awvalid, m_wready});
    end
    step();
    m_awvalid = 0; m_wvalid = 1; m_wlast = 1; m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF;
    #1;
    checks++;
    if ({m_wready, s1_wvalid, m_bvalid} !== 3'b100) begin
      failures++; $display("FAIL clint_drain got=%b exp=100", {m_wready, s1_wvalid, m_bvalid});
    end
    step();
    m_wvalid = 0; m_wlast = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({m_bvalid, m_bresp, m_bid, s1_bready, m_wready} !== {1'b1, 2'b11, 4'd3, 2'b00}) begin
        failures++;
        $display("FAIL clint_errb_hold got v=%b resp=%b id=%0d s1bry=%b wrdy=%b exp 1 11 3 0 0",
                 m_bvalid, m_bresp, m_bid, s1_bready, m_wready);
      end
      step();
    end
    m_bready = 1;
    step();
    m_bready = 0; s1_awready = 0; s1_wready = 0;
    #1;
    checks++;
    if ({m_bvalid, m_bid} !== 5'd0) begin
      failures++; $display("FAIL clint_errb_done got v=%b id=%0d exp 0 0", m_bvalid, m_bid);
    end
  endtask

  task automatic test_soc_write();
    m_awvalid = 1; m_awaddr = 32'hA000_0000; m_awlen = 8'd1; m_awid = 4'd7; s1_awready = 1;
    #1;
    checks++;
    if ({s1_awvalid, m_awready, s1_awaddr, s1_awlen, s1_awid} !==
        {2'b11, 32'hA000_0000, 8'd1, 4'd7}) begin
      failures++;
      $display("FAIL soc_aw got v=%b rdy=%b addr=%h len=%0d id=%0d exp 1 1 a0000000 1 7",
               s1_awvalid, m_awready, s1_awaddr, s1_awlen, s1_awid);
    end
    step();
    m_awvalid = 0; s1_awready = 0; s1_wready = 1;
    for (int b = 0; b < 2; b++) begin
      m_wvalid = 1; m_wdata = 32'h0000_0011 + b; m_wstrb = 4'hF; m_wlast = (b == 1);
      #1;
      checks++;
      if ({s1_wvalid, m_wready, s1_wdata, s1_wstrb, s1_wlast} !==
          {2'b11, 32'h0000_0011 + b, 4'hF, (b == 1)}) begin
        failures++;
        $display("FAIL soc_w%0d got v=%b rdy=%b d=%h strb=%h last=%b", b,
                 s1_wvalid, m_wready, s1_wdata, s1_wstrb, s1_wlast);
      end
      step();
    end
    m_wvalid = 0; m_wlast = 0; s1_wready = 0;
    s1_bvalid = 1; s1_bresp = 0; s1_bid = 4'd7; m_bready = 1;
    #1;
    checks++;
    if ({m_bvalid, m_bresp, m_bid, s1_bready} !== {1'b1, 2'd0, 4'd7, 1'b1}) begin
      failures++;
      $display("FAIL soc_b got v=%b resp=%0d id=%0d rdy=%b exp 1 0 7 1",
               m_bvalid, m_bresp, m_bid, s1_bready);
    end
    step();
    s1_bvalid = 0; m_bready = 0; m_awlen = 0;
    #1;
    checks++;
    if (m_bvalid !== 1'b0) begin
      failures++; $display("FAIL soc_b_done got=%b exp=0", m_bvalid);
    end
  endtask

  task automatic test_concurrent();
    m_arvalid = 1; m_araddr = 32'h0200_0004; m_arid = 4'd1; s0_arready = 1;
    m_awvalid = 1; m_awaddr = 32'h8000_0010; m_awid = 4'd4; s1_awready = 1;
    #1;
    checks++;
    if ({m_arready, m_awready, s0_arvalid, s1_awvalid, s1_arvalid} !== 5'b11110) begin
      failures++;
      $display("FAIL conc_addr got=%b exp=11110",
               {m_arready, m_awready, s0_arvalid, s1_awvalid, s1_arvalid});
    end
    step();
    m_arvalid = 0; s0_arready = 0; m_awvalid = 0; s1_awready = 0;
    s0_rvalid = 1; s0_rdata = 32'hCAFE_0001; m_rready = 1;
    m_wvalid = 1; m_wlast = 1; m_wdata = 32'h0000_00AA; s1_wready = 1;
    #1;
    checks++;
    if ({m_rvalid, m_rdata, m_rid, m_wready, s1_wvalid} !== {1'b1, 32'hCAFE_0001, 4'd1, 2'b11}) begin
      failures++;
      $display("FAIL conc_data got rv=%b d=%h id=%0d wrdy=%b s1wv=%b exp 1 cafe0001 1 1 1",
               m_rvalid, m_rdata, m_rid, m_wready, s1_wvalid);
    end
    step();
    s0_rvalid = 0; m_rready = 0; m_wvalid = 0; m_wlast = 0; s1_wready = 0;
    s1_bvalid = 1; s1_bid = 4'd4; s1_bresp = 0; m_bready = 1;
    #1;
    checks++;
    if ({m_bvalid, m_bid, m_rvalid} !== {1'b1, 4'd4, 1'b0}) begin
      failures++;
      $display("FAIL conc_b got bv=%b id=%0d rv=%b exp 1 4 0", m_bvalid, m_bid, m_rvalid);
    end
    step();
    s1_bvalid = 0; m_bready = 0;
  endtask

  task automatic test_reset_mid();
    m_arvalid = 1; m_araddr = 32'h8000_0000; m_arlen = 8'd3; m_arid = 4'd2; s1_arready = 1;
    step();
    m_arvalid = 0; s1_arready = 0;
    s1_rvalid = 1; s1_rdata = 32'hB000_0000; s1_rid = 4'd2; m_rready = 1;
    step();
    s1_rdata = 32'hB000_0001;
    reset = 1;
    step();
    reset = 0;
    m_araddr = 32'h0200_0008;  // CLINT decode, s0_arready low
    #1;
    checks++;
    if ({m_rvalid, m_arready, s1_rready, s0_rready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0000", {m_rvalid, m_arready, s1_rready, s0_rready});
    end
    s1_rvalid = 0; m_rready = 0; m_arlen = 0;
    m_arvalid = 1; m_arid = 4'd9; s0_arready = 1;
    #1;
    checks++;
    if ({m_arready, s0_arvalid, s1_arvalid} !== 3'b110) begin
      failures++; $display("FAIL reset_new_ar got=%b exp=110", {m_arready, s0_arvalid, s1_arvalid});
    end
    step();
    m_arvalid = 0; s0_arready = 0;
    s0_rvalid = 1; s0_rdata = 32'h0000_0055; m_rready = 1;
    #1;
    checks++;
    if ({m_rvalid, m_rdata, m_rid, m_rlast} !== {1'b1, 32'h0000_0055, 4'd9, 1'b1}) begin
      failures++;
      $display("FAIL reset_new_r got v=%b d=%h id=%0d last=%b exp 1 00000055 9 1",
               m_rvalid, m_rdata, m_rid, m_rlast);
    end
    step();
    s0_rvalid = 0; m_rready = 0;
  endtask

  initial begin
    test_reset();
    test_clint_read();
    test_soc_read();
    test_clint_write();
    test_soc_write();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
